// File: rtl/riscv_pkg.sv
`default_nettype none
// riscv_pkg: constants shared by the control decoder and the memory-mapped I/O stage.
package riscv_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [2:0] F3_IO    = 3'b111;

  // lw/sw with funct3 = 111 address the I/O ports instead of data memory.
  function automatic logic is_io_load(input logic [6:0] opcode, input logic [2:0] funct3);
    return (opcode == OP_LOAD) && (funct3 == F3_IO);
  endfunction

  function automatic logic is_io_store(input logic [6:0] opcode, input logic [2:0] funct3);
    return (opcode == OP_STORE) && (funct3 == F3_IO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_out_fifo.sv
`default_nettype none
// io_out_fifo: circular-buffer FIFO that buffers core writes to the external OUTPUT bus.
module io_out_fifo
  import riscv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers are exactly AW bits wide, so DEPTH being a power of two makes them wrap for free.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/io_port_unit.sv
`default_nettype none
// io_port_unit: memory-mapped I/O stage; one-word input holding register, output FIFO and core stall.
module io_port_unit
  import riscv_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEFAULT,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             InputSRC,
  input  logic             OutputSRC,
  input  logic [WIDTH-1:0] WriteData,
  output logic [WIDTH-1:0] ReadInput,
  output logic             io_stall,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(OFIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(OFIFO_DEPTH);

  typedef enum logic [0:0] {
    IN_EMPTY = 1'b0,
    IN_FULL  = 1'b1
  } in_state_e;

  in_state_e        in_state_q, in_state_d;
  logic [WIDTH-1:0] hold_q, hold_d;

  logic             fifo_push, fifo_pop;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;

  // A full FIFO stalls even when a pop is under way; the push retries next cycle.
  assign io_stall  = (InputSRC & (in_state_q == IN_EMPTY)) | (OutputSRC & fifo_full);
  assign in_ready  = (in_state_q == IN_EMPTY);
  assign ReadInput = hold_q;

  assign fifo_push = OutputSRC & ~io_stall;
  assign fifo_pop  = out_valid & out_ready;
  assign out_valid = ~fifo_empty;

  // Refill only from EMPTY and consume only from FULL, so the two never share a cycle.
  always_comb begin
    in_state_d = in_state_q;
    hold_d     = hold_q;
    case (in_state_q)
      IN_EMPTY: begin
        if (in_valid) begin
          in_state_d = IN_FULL;
          hold_d     = in_data;
        end
      end
      IN_FULL: begin
        if (InputSRC && !io_stall) in_state_d = IN_EMPTY;
      end
      default: in_state_d = IN_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state_q <= IN_EMPTY;
      hold_q     <= '0;
    end else begin
      in_state_q <= in_state_d;
      hold_q     <= hold_d;
    end
  end

  io_out_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (OFIFO_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (WriteData),
    .pop_i   (fifo_pop),
    .head_o  (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  a_full_matches_count: assert property (
    @(posedge clk) disable iff (!rst_n) fifo_full == (fifo_count == CNT_FULL)
  );

  a_count_in_range: assert property (
    @(posedge clk) disable iff (!rst_n) fifo_count <= CNT_FULL
  );

endmodule
`default_nettype wire

// File: doc/io_port_unit.md
# io_port_unit

Memory-mapped I/O stage for the single-cycle RISC-V core, directly downstream of the control decoder. It consumes the decoder's InputSRC strobe (lw with funct3 = 3'b111) and OutputSRC strobe (sw with funct3 = 3'b111). It buffers core writes to the external OUTPUT bus in a small FIFO and holds one word from the external INPUT bus for the core to read. When a request cannot complete this cycle, it raises a stall that freezes the PC and register-file write.

## Interface
Parameters:
- WIDTH, 32, data width of core and external buses
- OFIFO_DEPTH, 4, output FIFO entries; power of two, ≥2

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  reset; one clock, asynchronous, active-low
- InputSRC  in  1  decoder strobe: current instruction reads the INPUT bus
- OutputSRC  in  1  decoder strobe: current instruction writes RD2 to the OUTPUT bus
- WriteData  in  WIDTH  RD2 from the register file
- ReadInput  out  WIDTH  input word to the result mux; valid when InputSRC=1 and io_stall=0
- io_stall  out  1  combinational; 1 holds the PC and suppresses RegWrite this cycle
- in_data  in  WIDTH  external input word
- in_valid  in  1  external producer has a word
- in_ready  out  1  holding register empty
- out_data  out  WIDTH  FIFO head word
- out_valid  out  1  FIFO not empty
- out_ready  in  1  external consumer accepts the head

## Operation
- InputSRC and OutputSRC are never both 1, because the decoder produces them from different opcodes. If both are 1, behaviour is don't-care.
- Input holding register: states EMPTY and FULL.
  - EMPTY → FULL on in_valid & in_ready; the register captures in_data.
  - FULL → EMPTY on InputSRC & ~io_stall (the core consumes the word).
  - in_ready = (state == EMPTY); it is registered-state only and has no combinational path from InputSRC.
  - A consume and a refill never happen in the same cycle. Peak input throughput is one word per 2 cycles.
  - ReadInput = holding register contents; the value persists after consume until overwritten.
- Output FIFO: circular buffer with rd_ptr, wr_ptr (log2(OFIFO_DEPTH) bits, wrapping modulo depth) and count (log2(OFIFO_DEPTH)+1 bits).
  - Push on OutputSRC & ~io_stall; writes WriteData at wr_ptr.
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop: both pointers advance and count is unchanged.
  - out_data = mem[rd_ptr].
- Stall: io_stall = (InputSRC & state==EMPTY) | (OutputSRC & count==OFIFO_DEPTH).
  - A full FIFO stalls even if a pop occurs in the same cycle. The push completes on the following cycle.
  - While stalled, the decoder strobe stays asserted because the PC is frozen. The block holds no per-request state.

## Timing
- Reset values:
  - ReadInput = 0, in_ready = 1 (EMPTY).
  - out_valid = 0, out_data = 0 (all FIFO entries cleared).
  - Pointers and count = 0.
  - io_stall = 0 unless InputSRC is 1. Immediately after reset an input request stalls, because the holding register is EMPTY.
- Input latency: in_valid & in_ready at edge N → FULL from N; an InputSRC instruction in cycle N+1 completes without stall.
- Output latency: push at edge N → out_valid = 1 and out_data = the word during cycle N+1; earliest pop at edge N+1.
- Reset asserted mid-operation empties the FIFO (buffered words are lost) and the holding register, asynchronously. Outputs take their reset values immediately.
- io_stall, in_ready and out_valid are free of glitches on in_valid and out_ready; io_stall is combinational on the decoder strobes.

## Structure
- Shared package (riscv_pkg): WIDTH default; decoder encodings OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, F3_IO = 3'b111.
- The input-state enum {IN_EMPTY, IN_FULL} is local to the block.
- One sub-module: io_out_fifo (parameterised WIDTH/DEPTH; push/pop/full/empty/count/head). The holding register and stall logic stay in io_port_unit.

## Test plan
- Reset, then InputSRC=1 with in_valid=0 → io_stall=1 and in_ready=1. Then present in_data=32'hA5A5_0001 with in_valid=1 for one edge → next cycle io_stall=0 and ReadInput=32'hA5A5_0001; the cycle after, in_ready=1.
- Five consecutive OutputSRC pushes of 1..5 with out_ready=0, OFIFO_DEPTH=4:
  - pushes 1–4 complete with no stall;
  - the 5th holds io_stall=1 until one pop;
  - then draining with out_ready=1 yields out_data 1,2,3,4,5 in order, and out_valid falls after 5.
- FIFO full with push and pop requested in the same cycle → stall that cycle, pop occurs, push completes next cycle, count returns to 4.
- Continuous push/pop (out_ready=1, OutputSRC each cycle) for 10 words → count never exceeds 1, pointers wrap twice, no stall, data order preserved.
- in_valid held at 1 while the core issues InputSRC every cycle → words accepted on alternating edges; the core stalls on every other request.
- Assert rst_n=0 mid-drain with 3 words buffered → out_valid=0 and in_ready=1 immediately, without waiting for a clock edge; after release, a new push appears alone at out_data.
